dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: none; widths come from dmem_ctrl_pkg (ADDR_W=5, DATA_W=32, BYTE_W=8, BEATS=4).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 pN_req  in  1  (N=0,1) level request; requester holds it and its attributes stable until pN_gnt.
REQ-005 pN_we  in  1  1=word store, 0=word load.
REQ-006 pN_addr  in  5  byte address of word's least-significant byte; any alignment.
REQ-007 pN_wdata  in  32  store data.
REQ-008 pN_gnt  out  1  one-cycle pulse; attributes latched, access started.
REQ-009 pN_done  out  1  one-cycle pulse; access complete.
REQ-010 pN_rdata  out  32  load result; valid from pN_done, held until that port's next load completes.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 mem_sw  out  1  byte-write strobe to the byte-wide data memory (synchronous write).
REQ-013 mem_wr_addr, mem_rd_addr  out  5 each  memory write/read byte address.
REQ-014 mem_wr_data  out  32  byte to write, zero-extended to bits [31:8].
REQ-015 mem_rd_data  in  32  combinational memory read; only [7:0] is used.

Function
REQ-016 FSM states IDLE, BEAT, DONE; 2-bit beat counter valid in BEAT only.
REQ-017 IDLE: if any pN_req is high at edge T, the arbiter picks a winner, latches we/addr/wdata, sets beat=0, and enters BEAT at T+1.
REQ-018 pN_gnt is high during cycle T+1 (first BEAT cycle) for the winner only.
REQ-019 BEAT k (k=0..3) drives byte address (addr+k) mod 32 on both mem_wr_addr and mem_rd_addr; address wraps 31->0.
REQ-020 Store: mem_sw=1 in every BEAT cycle; mem_wr_data = wdata[8k+7:8k]; little-endian.
REQ-021 Load: mem_sw=0; mem_rd_data[7:0] captured into rdata[8k+7:8k] at the end of beat k.
REQ-022 After beat 3, the FSM enters DONE (cycle T+5) and pulses the winner's pN_done; it returns to IDLE at T+6.
REQ-023 Total latency: request sampled at T, done at T+5; one access at a time; next grant no earlier than T+7.
REQ-024 Arbitration is 2-way round-robin; the priority pointer moves to the other port after each grant; the lone requester always wins.
REQ-025 A requester still asserting pN_req when the FSM returns to IDLE is treated as a new request.
REQ-026 Requests are ignored outside IDLE (no queuing); gnt/done are never asserted for both ports in one cycle.
REQ-027 Outside BEAT: mem_sw=0, mem addresses=0, mem_wr_data=0.
REQ-028 A load's pN_rdata changes only at beat captures of that port's load; stores leave pN_rdata unchanged.

Reset
REQ-029 On rst: state=IDLE, beat=0, priority=port 0, latched attributes=0, pN_rdata=0, pN_gnt=pN_done=0, busy=0, mem_sw=0.
REQ-030 Reset mid-access aborts it: no pN_done; bytes already written stay in memory; no further writes after the reset edge.

Structure
REQ-031 dmem_ctrl_pkg holds the state enum, ADDR_W, DATA_W, BYTE_W, BEATS, and NUM_PORTS=2.
REQ-032 One sub-module, rr_arb2: request[1:0], advance, grant_onehot[1:0]; registered priority pointer, reset to port 0.

Verification (memory pre-initialised mem[i]=i)
REQ-033 p0 load addr 4 at T -> p0_gnt at T+1, p0_done at T+5, p0_rdata=0x07060504.
REQ-034 p1 store addr 8 data 0xDEADBEEF -> mem[8..11]=EF,BE,AD,DE; then p1 load addr 8 returns 0xDEADBEEF.
REQ-035 p0 load addr 30 -> addresses 30,31,0,1 issued; p0_rdata=0x01001F1E.
REQ-036 Both ports request continuously after reset -> grants alternate p0,p1,p0,p1; each done is 4 cycles after its gnt.
REQ-037 Store 0xAABBCCDD at addr 16 with rst asserted during beat 2 -> mem[16]=DD, mem[17]=CC, mem[18..19] unchanged; no done; FSM idle; next request served normally.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared widths and FSM state encoding for the byte-serial data memory controller.
package dmem_ctrl_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int BEATS     = 4;
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEAT = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer names the port preferred on a tie.
module rr_arb2
    import dmem_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] request,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] grant_onehot
);

    logic r_ptr;

    always_comb begin
        grant_onehot = request;
        if (request == 2'b11)
            grant_onehot = r_ptr ? 2'b10 : 2'b01;
    end

    // After a grant the other port gets preference.
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= 1'b0;
        else if (advance && |grant_onehot)
            r_ptr <= grant_onehot[0];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port word load/store controller over a byte-wide memory, one byte per beat.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              busy,
    output logic              mem_sw,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_beat;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_grant;
    logic                 w_start;
    logic                 w_win;
    logic [4:0]           w_bit;
    logic                 w_unused;

    assign w_req    = {p1_req, p0_req};
    assign w_start  = (r_state == S_IDLE) && |w_req;
    assign w_win    = w_grant[1];
    assign w_bit    = {r_beat, 3'b000};
    assign w_unused = ^mem_rd_data[DATA_W-1:BYTE_W];

    rr_arb2 u_arb (
        .clk          (clk),
        .rst          (rst),
        .request      (w_req),
        .advance      (w_start),
        .grant_onehot (w_grant)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (|w_req) w_next = S_BEAT;
            S_BEAT: if (r_beat == 2'(BEATS - 1)) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_beat   <= 2'd0;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_owner <= w_win;
                r_we    <= w_win ? p1_we    : p0_we;
                r_addr  <= w_win ? p1_addr  : p0_addr;
                r_wdata <= w_win ? p1_wdata : p0_wdata;
                r_beat  <= 2'd0;
            end else if (r_state == S_BEAT) begin
                r_beat <= r_beat + 2'd1;
            end
            // Loads assemble little-endian, one byte lane per beat.
            if (r_state == S_BEAT && !r_we) begin
                if (r_owner)
                    r_rdata1[w_bit +: BYTE_W] <= mem_rd_data[BYTE_W-1:0];
                else
                    r_rdata0[w_bit +: BYTE_W] <= mem_rd_data[BYTE_W-1:0];
            end
        end
    end

    always_comb begin
        mem_sw      = 1'b0;
        mem_wr_addr = '0;
        mem_rd_addr = '0;
        mem_wr_data = '0;
        p0_gnt      = 1'b0;
        p1_gnt      = 1'b0;
        p0_done     = 1'b0;
        p1_done     = 1'b0;
        if (r_state == S_BEAT) begin
            mem_wr_addr = r_addr + ADDR_W'(r_beat);
            mem_rd_addr = r_addr + ADDR_W'(r_beat);
            // Reset edge must not commit the in-flight byte.
            mem_sw      = r_we && !rst;
            mem_wr_data = {{(DATA_W-BYTE_W){1'b0}}, r_wdata[w_bit +: BYTE_W]};
            p0_gnt      = (r_beat == 2'd0) && !r_owner;
            p1_gnt      = (r_beat == 2'd0) &&  r_owner;
        end
        if (r_state == S_DONE) begin
            p0_done = !r_owner;
            p1_done =  r_owner;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign p0_rdata = r_rdata0;
    assign p1_rdata = r_rdata1;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a byte-wide memory model preset to mem[i]=i.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [4:0]  p0_addr = '0;
    logic [31:0] p0_wdata = '0;
    logic        p0_gnt, p0_done;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [4:0]  p1_addr = '0;
    logic [31:0] p1_wdata = '0;
    logic        p1_gnt, p1_done;
    logic [31:0] p1_rdata;
    logic        busy, mem_sw;
    logic [4:0]  mem_wr_addr, mem_rd_addr;
    logic [31:0] mem_wr_data, mem_rd_data;

    logic [7:0]  mem [32];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
        .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
        .p1_rdata(p1_rdata),
        .busy(busy), .mem_sw(mem_sw),
        .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always @(posedge clk)
        if (mem_sw) mem[mem_wr_addr] <= mem_wr_data[7:0];

    assign mem_rd_data = {24'h0, mem[mem_rd_addr]};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic access(input bit p, input bit we, input logic [4:0] a,
                          input logic [31:0] wd);
        @(negedge clk);
        if (p) begin
            p1_we = we; p1_addr = a; p1_wdata = wd; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = a; p0_wdata = wd; p0_req = 1'b1;
        end
        @(negedge clk);
        chk("acc_gnt", {30'h0, p1_gnt, p0_gnt}, p ? 32'h2 : 32'h1);
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("acc_done", {30'h0, p1_done, p0_done}, p ? 32'h2 : 32'h1);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_gnt", {30'h0, p1_gnt, p0_gnt}, 32'h0);
        chk("rst_done", {30'h0, p1_done, p0_done}, 32'h0);
        chk("rst_rdata0", p0_rdata, 32'h0);
        chk("rst_rdata1", p1_rdata, 32'h0);
        chk("rst_sw", {31'h0, mem_sw}, 32'h0);
        chk("rst_addr", {27'h0, mem_rd_addr}, 32'h0);

        // p0 load at 4
        p0_we = 1'b0; p0_addr = 5'd4; p0_req = 1'b1;
        @(negedge clk);
        chk("ld4_gnt", {30'h0, p1_gnt, p0_gnt}, 32'h1);
        chk("ld4_busy", {31'h0, busy}, 32'h1);
        chk("ld4_addr0", {27'h0, mem_rd_addr}, 32'd4);
        chk("ld4_sw", {31'h0, mem_sw}, 32'h0);
        p0_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("ld4_addr3", {27'h0, mem_rd_addr}, 32'd7);
        chk("ld4_early_done", {31'h0, p0_done}, 32'h0);
        @(negedge clk);
        chk("ld4_done", {30'h0, p1_done, p0_done}, 32'h1);
        chk("ld4_rdata", p0_rdata, 32'h07060504);
        chk("ld4_idle_addr", {27'h0, mem_rd_addr}, 32'h0);
        @(negedge clk);
        chk("ld4_idle", {31'h0, busy}, 32'h0);

        // p1 store at 8
        p1_we = 1'b1; p1_addr = 5'd8; p1_wdata = 32'hDEADBEEF; p1_req = 1'b1;
        @(negedge clk);
        chk("st8_gnt", {30'h0, p1_gnt, p0_gnt}, 32'h2);
        chk("st8_sw", {31'h0, mem_sw}, 32'h1);
        chk("st8_wdata0", mem_wr_data, 32'h000000EF);
        chk("st8_waddr0", {27'h0, mem_wr_addr}, 32'd8);
        p1_req = 1'b0;
        @(negedge clk);
        chk("st8_wdata1", mem_wr_data, 32'h000000BE);
        repeat (3) @(negedge clk);
        chk("st8_done", {30'h0, p1_done, p0_done}, 32'h2);
        chk("st8_mem", {mem[11], mem[10], mem[9], mem[8]}, 32'hDEADBEEF);
        chk("st8_rdata1", p1_rdata, 32'h0);
        chk("st8_done_sw", {31'h0, mem_sw}, 32'h0);
        @(negedge clk);
        access(1'b1, 1'b0, 5'd8, 32'h0);
        chk("ld8_rdata1", p1_rdata, 32'hDEADBEEF);
        chk("ld8_rdata0", p0_rdata, 32'h07060504);

        // p0 load wrapping 30,31,0,1
        p0_we = 1'b0; p0_addr = 5'd30; p0_req = 1'b1;
        @(negedge clk);
        p0_req = 1'b0;
        chk("ld30_a0", {27'h0, mem_rd_addr}, 32'd30);
        @(negedge clk);
        chk("ld30_a1", {27'h0, mem_rd_addr}, 32'd31);
        @(negedge clk);
        chk("ld30_a2", {27'h0, mem_rd_addr}, 32'd0);
        @(negedge clk);
        chk("ld30_a3", {27'h0, mem_rd_addr}, 32'd1);
        @(negedge clk);
        chk("ld30_done", {31'h0, p0_done}, 32'h1);
        chk("ld30_rdata", p0_rdata, 32'h01001F1E);
        @(negedge clk);

        // fresh reset so the pointer starts at port 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        p0_we = 1'b0; p0_addr = 5'd0;
        p1_we = 1'b0; p1_addr = 5'd4;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit got;
            bit who;
            got = 1'b0;
            who = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (p0_gnt || p1_gnt) begin
                    got = 1'b1;
                    who = p1_gnt;
                end
            end
            chk("rr_gnt_seen", {31'h0, got}, 32'h1);
            chk("rr_gnt_port", {30'h0, p1_gnt, p0_gnt},
                (i % 2) ? 32'h2 : 32'h1);
            repeat (3) @(negedge clk);
            chk("rr_no_early_done", {30'h0, p1_done, p0_done}, 32'h0);
            @(negedge clk);
            chk("rr_done", {30'h0, p1_done, p0_done},
                who ? 32'h2 : 32'h1);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rr_idle", {31'h0, busy}, 32'h0);
        chk("rr_rdata0", p0_rdata, 32'h03020100);
        chk("rr_rdata1", p1_rdata, 32'h07060504);

        // store aborted by reset in beat 2
        p0_we = 1'b1; p0_addr = 5'd16; p0_wdata = 32'hAABBCCDD; p0_req = 1'b1;
        @(negedge clk);
        chk("ab_gnt", {31'h0, p0_gnt}, 32'h1);
        p0_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("ab_beat2_addr", {27'h0, mem_wr_addr}, 32'd18);
        rst = 1'b1;
        #1;
        chk("ab_sw_gated", {31'h0, mem_sw}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("ab_busy", {31'h0, busy}, 32'h0);
        chk("ab_mem", {mem[19], mem[18], mem[17], mem[16]}, 32'h1312CCDD);
        repeat (3) @(negedge clk);
        chk("ab_no_done", {30'h0, p1_done, p0_done}, 32'h0);
        chk("ab_mem_after", {mem[19], mem[18]}, 32'h1312);
        access(1'b1, 1'b0, 5'd16, 32'h0);
        chk("ab_reload", p1_rdata, 32'h1312CCDD);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
